uart_result_tx: RTL and testbench

UART transmit path for the calculator. It accepts one arithmetic result from the calculator core through a valid/ready handshake. It formats the result as an ASCII hex string, with an optional leading '-', followed by CR LF. It serialises the string on txd as 8N1 frames at the same bit rate the receive path expects (16 clocks per bit at 10 ns, so 160 ns per bit). It sits between the calculator core and the top-level txd/tx_valid pins.

---
 rtl/uart_result_tx.sv | 199 +++++++++++++++++++
 tb/tb_uart_result_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// UART transmit path for calculator results: formats a signed hex result as
// ASCII ('-' optional, N_DIGITS hex digits, CR LF) and sends it as 8N1 frames.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int N_DIGITS     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [4*N_DIGITS-1:0] res_data,
    input  logic                  res_neg,
    output logic                  txd,
    output logic                  tx_valid,
    output logic                  done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CIDX_W = $clog2(N_DIGITS + 4);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CIDX_W-1:0] DIGITS_C  = CIDX_W'(N_DIGITS);
    localparam logic [CIDX_W-1:0] CIDX_ZERO = {CIDX_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

    // Character at message position idx; digits start at position neg.
    function automatic logic [7:0] char_at(
        input logic [CIDX_W-1:0]     idx,
        input logic [4*N_DIGITS-1:0] data,
        input logic                  neg
    );
        logic [CIDX_W-1:0] pos;
        logic [3:0]        nib;
        logic [7:0]        c;
        pos = idx - {{(CIDX_W-1){1'b0}}, neg};
        nib = 4'h0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (pos == CIDX_W'(i)) begin
                nib = data[4*(N_DIGITS-1-i) +: 4];
            end else begin
                nib = nib;
            end
        end
        if (neg && (idx == CIDX_ZERO)) begin
            c = 8'h2D;
        end else if (pos < DIGITS_C) begin
            c = hex_ascii(nib);
        end else if (pos == DIGITS_C) begin
            c = 8'h0D;
        end else begin
            c = 8'h0A;
        end
        return c;
    endfunction

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [CIDX_W-1:0]     char_q, char_d;
    logic [4*N_DIGITS-1:0] data_q, data_d;
    logic                  neg_q, neg_d;
    logic                  txd_q, txd_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  done_q, done_d;

    logic                  baud_last_s;
    logic [CIDX_W-1:0]     last_idx_s;
    logic [7:0]            cur_char_s;

    assign baud_last_s = (baud_q == BAUD_LAST);
    assign last_idx_s  = DIGITS_C + CIDX_W'(1) + {{(CIDX_W-1){1'b0}}, neg_q};

    // State, counters, data latch and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= {BAUD_W{1'b0}};
            bit_q      <= 3'd0;
            char_q     <= CIDX_ZERO;
            data_q     <= {(4*N_DIGITS){1'b0}};
            neg_q      <= 1'b0;
            txd_q      <= 1'b1;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            char_q     <= char_d;
            data_q     <= data_d;
            neg_q      <= neg_d;
            txd_q      <= txd_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        data_d  = data_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (res_valid) begin
                    state_d = S_START;
                    baud_d  = {BAUD_W{1'b0}};
                    bit_d   = 3'd0;
                    char_d  = CIDX_ZERO;
                    data_d  = res_data;
                    neg_d   = res_neg;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_last_s) begin
                    state_d = S_DATA;
                    baud_d  = {BAUD_W{1'b0}};
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (char_q == last_idx_s) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                        char_d  = char_q + CIDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = {BAUD_W{1'b0}};
                bit_d   = 3'd0;
                char_d  = CIDX_ZERO;
            end
        endcase
    end

    // Line level is decoded from the next state so txd is registered yet on time;
    // the character index never changes on a START->DATA transition.
    always_comb begin
        cur_char_s = char_at(char_q, data_q, neg_q);
        txd_d      = 1'b1;
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = cur_char_s[bit_d];
            S_STOP:  txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
        tx_valid_d = (state_d != S_IDLE);
    end

    assign res_ready = (state_q == S_IDLE);
    assign txd       = txd_q;
    assign tx_valid  = tx_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: vector table of results, a frame-decoding monitor
// and a scoreboard queue of expected characters.
module tb_uart_result_tx;

    localparam int CPB        = 16;
    localparam int ND         = 8;
    localparam int FRAME      = 10 * CPB;
    localparam int MSG_BUDGET = 12 * FRAME + 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_data;
    logic          res_neg;
    logic          txd;
    logic          tx_valid;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        neg;
        logic [3:0]  len;
        logic [87:0] text;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_q [$];

    uart_result_tx #(.CLKS_PER_BIT(CPB), .N_DIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_neg   (res_neg),
        .txd       (txd),
        .tx_valid  (tx_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic n, input logic [3:0] l,
                                input logic [87:0] s);
        vec_t v;
        v.data = d;
        v.neg  = n;
        v.len  = l;
        v.text = s;
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        for (int i = 0; i < int'(v.len); i++) begin
            exp_q.push_back(v.text[8*(int'(v.len)-1-i) +: 8]);
        end
    endtask

    task automatic accept(input vec_t v);
        @(negedge clk);
        res_data  = v.data;
        res_neg   = v.neg;
        res_valid = 1'b1;
        check("ready_before_accept", res_ready, 1);
        @(posedge clk);
        push_exp(v);
    endtask

    // Follows one message from the accept edge to done; busy=1 also presents
    // a result that is withdrawn, then holds 0x20 valid through the done cycle.
    task automatic track(input int len, input bit busy);
        int  valid_cyc;
        int  cyc;
        bit  ok;
        valid_cyc = 0;
        cyc       = 0;
        ok        = 1'b0;
        for (int c = 1; c <= MSG_BUDGET; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("first_start_bit", txd, 0);
                check("tx_valid_rise", tx_valid, 1);
                check("ready_busy", res_ready, 0);
                check("no_done_at_start", done, 0);
                if (busy) begin
                    res_valid = 1'b1;
                    res_data  = 32'h12345678;
                    res_neg   = 1'b0;
                end else begin
                    res_valid = 1'b0;
                end
            end
            if (busy && c == 50) res_valid = 1'b0;
            if (busy && c == 80) begin
                res_valid = 1'b1;
                res_data  = 32'h00000020;
                res_neg   = 1'b0;
            end
            if (done) begin
                cyc = c;
                ok  = 1'b1;
                break;
            end
            if (tx_valid) valid_cyc++;
        end
        check("done_seen", ok, 1);
        if (ok) begin
            check("msg_cycles", cyc - 1, len * FRAME);
            check("tx_valid_cycles", valid_cyc, len * FRAME);
            check("done_txd_idle", txd, 1);
            check("done_tx_valid_low", tx_valid, 0);
            check("done_ready", res_ready, 1);
        end
    endtask

    // Frame monitor: samples mid-bit, checks start/stop, pops the scoreboard.
    int         mon_cnt = 0;
    bit         mon_active = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            mon_active <= 1'b0;
            mon_cnt    <= 0;
        end else if (!mon_active) begin
            if (tx_valid && !txd) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == CPB/2) begin
                check("start_bit", txd, 0);
                check("tx_valid_in_frame", tx_valid, 1);
            end
            if (mon_cnt == CPB - 1) check("start_bit_width", txd, 0);
            if (mon_cnt >= CPB + CPB/2 && mon_cnt <= 8*CPB + CPB/2 && (mon_cnt % CPB) == CPB/2) begin
                mon_byte <= {txd, mon_byte[7:1]};
            end
            if (mon_cnt == 9*CPB + CPB/2) begin
                check("stop_bit", txd, 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL char_unexpected: got %02h, expected no character", mon_byte);
                end else begin
                    check("char", mon_byte, exp_q.pop_front());
                end
            end
            if (mon_cnt == FRAME - 1) mon_active <= 1'b0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(32'h0000000C, 1'b0, 4'd10, "0000000C\r\n");
        vecs[1] = mk(32'h00000002, 1'b0, 4'd10, "00000002\r\n");
        vecs[2] = mk(32'h00000015, 1'b1, 4'd11, "-00000015\r\n");
        vecs[3] = mk(32'h0123ABCF, 1'b0, 4'd10, "0123ABCF\r\n");
        vecs[4] = mk(32'hFFFFFFFF, 1'b1, 4'd11, "-FFFFFFFF\r\n");
        vecs[5] = mk(32'h9A5E7D0B, 1'b0, 4'd10, "9A5E7D0B\r\n");

        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = 32'h0;
        res_neg   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_done", done, 0);
        check("rst_ready", res_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            accept(vecs[i]);
            track(int'(vecs[i].len), 1'b0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("queue_drained", exp_q.size(), 0);
        end

        // Backpressure: only the value still valid on the done cycle is taken.
        accept(vecs[0]);
        track(10, 1'b1);
        check("bp_valid_on_done", res_valid, 1);
        @(posedge clk);
        push_exp(mk(32'h00000020, 1'b0, 4'd10, "00000020\r\n"));
        track(10, 1'b0);
        @(negedge clk);
        check("bp_queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the data bits of the third character.
        accept(vecs[3]);
        for (int c = 1; c <= 2*FRAME + CPB + 40; c++) begin
            @(negedge clk);
            if (c == 1) res_valid = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("abort_txd", txd, 1);
        check("abort_tx_valid", tx_valid, 0);
        check("abort_ready", res_ready, 1);
        check("abort_done", done, 0);
        check("abort_chars_left", exp_q.size(), 8);
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        accept(vecs[1]);
        track(10, 1'b0);
        @(negedge clk);
        check("post_rst_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
